// File: rtl/t5_fetch_ctrl.sv
// t5_fetch_ctrl -- instruction fetch controller.
//
// Drives a single-beat instruction bus and hands instructions to decode.
// Fetches run back to back at one per cycle when decode keeps up. If decode
// holds, the returned word is parked in a buffer. A redirect (bra) either
// retargets immediately, when no bus cycle is waiting, or is remembered in
// tpc. In that second case the outstanding bus cycle is allowed to finish
// before the new address is used.
//
// Ports:
//   sclk, srst      clock, synchronous active-high reset
//   sexe            run enable (0 = issue no new fetches)
//   bra, bpc        redirect request and target (bpc[1:0] ignored)
//   dhld            decode hold
//   iwb_ack/iwb_dat instruction bus acknowledge / read data
//   iwb_adr         word address, fpc[31:2]
//   iwb_stb/iwb_cyc bus strobe / cycle (identical)
//   fpc             PC of the instruction presented to decode
//   ireg            instruction presented to decode
//   sena            decode captures ireg/fpc on this edge
//   dbg_state       current FSM state (IDLE=0, FETCH=1, HOLD=2, FLUSH=3)
//
// Handshake: the bus transfers one word on a cycle where iwb_stb=1 and
// iwb_ack=1. The address is held stable until that happens. Decode takes a
// word on a cycle where sena=1. sena already accounts for dhld and bra.

module t5_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        sexe,
    input  logic        bra,
    input  logic [31:0] bpc,
    input  logic        dhld,
    input  logic        iwb_ack,
    input  logic [31:0] iwb_dat,
    output logic [29:0] iwb_adr,
    output logic        iwb_stb,
    output logic        iwb_cyc,
    output logic [31:0] fpc,
    output logic [31:0] ireg,
    output logic        sena,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] tpc_q, tpc_d;
    logic [31:0] buf_q, buf_d;
    logic        sena_c;

    // Word-aligned views of the redirect target and the next sequential PC.
    logic [31:0] bpc_al;
    logic [31:0] fpc_inc;

    assign bpc_al  = bpc & 32'hFFFF_FFFC;
    assign fpc_inc = fpc_q + 32'd4;   // wraps modulo 2^32

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC & 32'hFFFF_FFFC;
            tpc_q   <= 32'h0;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            tpc_q   <= tpc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        tpc_d   = tpc_q;
        buf_d   = buf_q;
        sena_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bra) fpc_d = bpc_al;
                if (sexe) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (iwb_ack) begin
                    if (bra) begin
                        // The returned word belongs to the old path, so drop it.
                        fpc_d = bpc_al;
                    end else if (dhld) begin
                        buf_d   = iwb_dat;
                        state_d = S_HOLD;
                    end else begin
                        sena_c  = 1'b1;
                        fpc_d   = fpc_inc;
                        state_d = sexe ? S_FETCH : S_IDLE;
                    end
                end else if (bra) begin
                    // The bus cycle cannot be aborted. Remember the target.
                    tpc_d   = bpc_al;
                    state_d = S_FLUSH;
                end
            end

            S_HOLD: begin
                if (bra) begin
                    fpc_d   = bpc_al;
                    state_d = S_FETCH;
                end else if (!dhld) begin
                    sena_c  = 1'b1;
                    fpc_d   = fpc_inc;
                    state_d = sexe ? S_FETCH : S_IDLE;
                end
            end

            S_FLUSH: begin
                if (bra) tpc_d = bpc_al;
                if (iwb_ack) begin
                    fpc_d   = bra ? bpc_al : tpc_q;
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign iwb_stb   = (state_q == S_FETCH) || (state_q == S_FLUSH);
    assign iwb_cyc   = iwb_stb;
    assign iwb_adr   = fpc_q[31:2];
    assign fpc       = fpc_q;
    assign ireg      = (state_q == S_HOLD) ? buf_q : iwb_dat;
    assign sena      = sena_c & ~srst;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_t5_fetch_ctrl.sv
// Bench for t5_fetch_ctrl. A table of per-cycle vectors is applied to a
// default-reset instance. A short hand-written sequence then exercises PC
// wrap on a second instance with RESET_PC=32'hFFFFFFFC.

module tb_t5_fetch_ctrl;

    logic        sclk = 1'b0;
    logic        srst, sexe, bra, dhld, iwb_ack;
    logic [31:0] bpc, iwb_dat;

    logic [29:0] iwb_adr, w_adr;
    logic        iwb_stb, iwb_cyc, sena, w_stb, w_cyc, w_sena;
    logic [31:0] fpc, ireg, w_fpc, w_ireg;
    logic [1:0]  dbg_state, w_state;

    int n_vec = 0;
    int n_err = 0;

    logic [65:0] exp_q[$];

    typedef struct {
        logic        srst, sexe, bra;
        logic [31:0] bpc;
        logic        dhld, ack;
        logic [31:0] dat;
        logic        stb, sena;
        logic [31:0] fpc, ireg;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock ----------------
    always #5 sclk = ~sclk;

    // ---------------- DUTs ----------------
    t5_fetch_ctrl u_dut (
        .sclk(sclk), .srst(srst), .sexe(sexe), .bra(bra), .bpc(bpc),
        .dhld(dhld), .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_cyc(iwb_cyc),
        .fpc(fpc), .ireg(ireg), .sena(sena), .dbg_state(dbg_state)
    );

    t5_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .sclk(sclk), .srst(srst), .sexe(sexe), .bra(bra), .bpc(bpc),
        .dhld(dhld), .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
        .iwb_adr(w_adr), .iwb_stb(w_stb), .iwb_cyc(w_cyc),
        .fpc(w_fpc), .ireg(w_ireg), .sena(w_sena), .dbg_state(w_state)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int idx,
                       input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, e, b, input logic [31:0] p,
                       input logic h, a, input logic [31:0] d,
                       input logic x_stb, x_sena,
                       input logic [31:0] x_fpc, x_ireg);
        vec_t v;
        v.srst = r; v.sexe = e; v.bra = b; v.bpc = p;
        v.dhld = h; v.ack = a; v.dat = d;
        v.stb = x_stb; v.sena = x_sena; v.fpc = x_fpc; v.ireg = x_ireg;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, e, b, input logic [31:0] p,
                         input logic h, a, input logic [31:0] d);
        @(negedge sclk);
        srst = r; sexe = e; bra = b; bpc = p;
        dhld = h; iwb_ack = a; iwb_dat = d;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [65:0] exp;
        int          k;

        srst = 1'b1; sexe = 1'b0; bra = 1'b0; bpc = 32'h0;
        dhld = 1'b0; iwb_ack = 1'b0; iwb_dat = 32'h0;

        //   srst sexe bra bpc           dhld ack dat            stb sena fpc           ireg
        // reset overrides everything
        add(1, 1, 1, 32'h0000_0500, 0, 1, 32'h0000_00AA,  0, 0, 32'h0000_0000, 32'h0000_00AA);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0000, 32'h0);
        // streaming: fpc 0,4,8,C on consecutive acks
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0011,  1, 1, 32'h0000_0000, 32'h0000_0011);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0022,  1, 1, 32'h0000_0004, 32'h0000_0022);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0033,  1, 1, 32'h0000_0008, 32'h0000_0033);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0044,  1, 1, 32'h0000_000C, 32'h0000_0044);
        // wait states: address held
        add(0, 1, 0, 32'h0,         0, 0, 32'h0000_0055,  1, 0, 32'h0000_0010, 32'h0000_0055);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0000_0056,  1, 0, 32'h0000_0010, 32'h0000_0056);
        // hold: dhld high for 3 cycles, buffered word shown, ack in HOLD ignored
        add(0, 1, 0, 32'h0,         1, 1, 32'h0000_0013,  1, 0, 32'h0000_0010, 32'h0000_0013);
        add(0, 1, 0, 32'h0,         1, 1, 32'h0000_DEAD,  0, 0, 32'h0000_0010, 32'h0000_0013);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0000_BEEF,  0, 0, 32'h0000_0010, 32'h0000_0013);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 1, 32'h0000_0010, 32'h0000_0013);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0014, 32'h0);
        // flush: redirect while waiting, ack two cycles later
        add(0, 1, 1, 32'h0000_0103, 0, 0, 32'h0,          1, 0, 32'h0000_0014, 32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0014, 32'h0);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0077,  1, 0, 32'h0000_0014, 32'h0000_0077);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0100, 32'h0);
        // flush: latest redirect wins
        add(0, 1, 1, 32'h0000_0300, 0, 0, 32'h0,          1, 0, 32'h0000_0100, 32'h0);
        add(0, 1, 1, 32'h0000_0404, 0, 0, 32'h0,          1, 0, 32'h0000_0100, 32'h0);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0000_0078,  1, 0, 32'h0000_0100, 32'h0000_0078);
        // ack and redirect in the same cycle
        add(0, 1, 1, 32'h0000_0200, 0, 1, 32'h0000_0099,  1, 0, 32'h0000_0404, 32'h0000_0099);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0200, 32'h0);
        // redirect beats hold
        add(0, 1, 0, 32'h0,         1, 1, 32'h0000_CAFE,  1, 0, 32'h0000_0200, 32'h0000_CAFE);
        add(0, 1, 1, 32'h0000_0602, 1, 0, 32'h0000_1111,  0, 0, 32'h0000_0200, 32'h0000_CAFE);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0600, 32'h0);
        // flush ending with ack plus fresh redirect
        add(0, 1, 1, 32'h0000_0700, 0, 0, 32'h0,          1, 0, 32'h0000_0600, 32'h0);
        add(0, 1, 1, 32'h0000_0808, 0, 1, 32'h0000_0079,  1, 0, 32'h0000_0600, 32'h0000_0079);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0808, 32'h0);
        // sexe drops mid-fetch: instruction still delivered, then IDLE
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0808, 32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_00EE,  1, 1, 32'h0000_0808, 32'h0000_00EE);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_00EF,  0, 0, 32'h0000_080C, 32'h0000_00EF);
        // redirect in IDLE loads fpc aligned
        add(0, 0, 1, 32'h0000_0A01, 0, 0, 32'h0,          0, 0, 32'h0000_080C, 32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0A00, 32'h0);
        // reset during FLUSH, late ack ignored
        add(0, 1, 1, 32'h0000_0B00, 0, 0, 32'h0,          1, 0, 32'h0000_0A00, 32'h0);
        add(1, 1, 0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h0000_0A00, 32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_0123,  0, 0, 32'h0000_0000, 32'h0000_0123);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0000, 32'h0);
        // sexe low while in HOLD: deliver then IDLE
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0000, 32'h0);
        add(0, 1, 0, 32'h0,         1, 1, 32'h0000_0005,  1, 0, 32'h0000_0000, 32'h0000_0005);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0000_0006,  0, 1, 32'h0000_0000, 32'h0000_0005);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0004, 32'h0);
        // reset while ack arrives: sena suppressed, strobe drops
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 0, 32'h0000_0004, 32'h0);
        add(1, 1, 0, 32'h0,         0, 1, 32'h0000_0007,  1, 0, 32'h0000_0004, 32'h0000_0007);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_0008,  0, 0, 32'h0000_0000, 32'h0000_0008);

        // unchecked reset cycle so state is defined before the table starts
        @(negedge sclk);
        @(negedge sclk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].srst, vecs[i].sexe, vecs[i].bra, vecs[i].bpc,
                  vecs[i].dhld, vecs[i].ack, vecs[i].dat);
            exp_q.push_back({vecs[i].stb, vecs[i].sena, vecs[i].fpc, vecs[i].ireg});
            #1;
            exp = exp_q.pop_front();
            chk("stb_sena_fpc_ireg", i, {iwb_stb, sena, fpc, ireg}, exp);
            chk("iwb_adr", i, {36'h0, iwb_adr}, {36'h0, exp[63:34]});
            chk("iwb_cyc", i, {65'h0, iwb_cyc}, {65'h0, exp[65]});
        end

        // ---------------- wrap sequence on RESET_PC=FFFFFFFC ----------------
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("wrap_reset_fpc", 100, {34'h0, w_fpc}, {34'h0, 32'hFFFF_FFFC});
        chk("wrap_reset_stb", 101, {65'h0, w_stb}, 66'h0);
        k = 0;
        while (!w_stb && k < 8) begin
            @(negedge sclk);
            #1;
            k++;
        end
        chk("wrap_stb_wait", 102, {65'h0, w_stb}, 66'h1);
        chk("wrap_adr", 103, {36'h0, w_adr}, {36'h0, 30'h3FFF_FFFF});
        drive(0, 1, 0, 32'h0, 0, 1, 32'h0000_00F0);
        #1;
        chk("wrap_sena", 104, {65'h0, w_sena}, 66'h1);
        chk("wrap_ireg", 105, {34'h0, w_ireg}, {34'h0, 32'h0000_00F0});
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("wrap_fpc", 106, {34'h0, w_fpc}, 66'h0);
        chk("wrap_adr0", 107, {36'h0, w_adr}, 66'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
